video_sync_h_gen: RTL and testbench
===================================

Name: video_sync_h_gen

Overview:
Parametrised horizontal video timing generator for the video subsystem. It counts 7 MHz pixel cycles (cend strobes from the DRAM controller) and produces the following: hblank and hsync levels, one-clock strobes for line/sync/scan-in/INT start, the pixel gate hpix, and fetch start/end strobes for the fetcher. It supersedes the fixed Pentagon/ATM generator. Line period, sync/blank positions and four pixel-window modes are parameters. The selected mode is shadowed so it changes only on a line boundary. hsync polarity is selectable, and the raw horizontal count is exported.

Parameters:
CW, 9, width of the horizontal counter.
HPERIOD, 448, line length in cend cycles.
HSYNC_BEG, 10, hcount at which hsync asserts.
HSYNC_END, 43, hcount at which hsync deasserts.
HBLNK_END, 88, hcount at which hblank deasserts (blank begins at 0).
SCANIN_BEG, 88, scan-doubler store start.
HINT_BEG, 2, INT start position.
FETCH_FOREGO, 18, cycles from fetch_start to hpix.
FETCH_WAIT, 4, extra delay stages in non-text modes (>=1).
HPIX_BEG_0/HPIX_END_0, 140/396, mode 0 (Pentagon 256).
HPIX_BEG_1/HPIX_END_1, 108/428, mode 1 (ATM 320).
HPIX_BEG_2/HPIX_END_2, 124/412, mode 2 (288 px).
HPIX_BEG_3/HPIX_END_3, 100/436, mode 3 (336 px).

Ports:
clk  in  1  system clock (28 MHz)
rst_n  in  1  reset; asynchronous, active-low
init  in  1  phase init, sampled when cend=1
cend  in  1  pixel-cycle strobe
pre_cend  in  1  strobe one clk before cend
mode_sel  in  2  pixel-window mode request
mode_a_text  in  1  text mode: fetch without FETCH_WAIT delay
hsync_pol  in  1  0: active-high hsync, 1: active-low
hcount  out  CW  current horizontal count
hblank  out  1  blank level
hsync  out  1  sync level (after polarity)
line_start  out  1  strobe
hsync_start  out  1  strobe
scanin_start  out  1  strobe
hint_start  out  1  strobe
hpix  out  1  pixel gate
fetch_start  out  1  strobe
fetch_end  out  1  strobe
line_end  out  1  strobe, last cycle of line

Behaviour:
- Reset (rst_n=0, async) forces the following; hsync output reset value is hsync_pol (inactive level):
  - hcount=0 and mode_r=0;
  - fetch delay pipeline = 0;
  - all strobes, hblank and hpix = 0.
- Counter:
  - On clk with cend=1: if init or hcount==HPERIOD-1, hcount<=0; else hcount<=hcount+1.
  - No change without cend.
- Mode shadow: mode_r<=mode_sel on cend when init or hcount==HPERIOD-1.
  - All window compares use mode_r; mid-line mode_sel changes have no effect until wrap.
- Levels are updated on cend from the pre-increment hcount:
  - hblank set at 0, cleared at HBLNK_END.
  - Internal sync set at HSYNC_BEG, cleared at HSYNC_END; hsync = sync XOR hsync_pol.
  - hpix set at HPIX_BEG[mode_r], cleared at HPIX_END[mode_r].
- Strobes: registered, high for exactly one clk, the clk after pre_cend=1 (coincides with cend), else 0.
  - hsync_start at hcount==HSYNC_BEG
  - line_start at HBLNK_END
  - scanin_start at SCANIN_BEG
  - hint_start at HINT_BEG
  - fetch_end at HPIX_END[mode_r]-FETCH_FOREGO
  - line_end at HPERIOD-1
- Fetch start:
  - fetch_time = (hcount == HPIX_BEG[mode_r]-FETCH_FOREGO-FETCH_WAIT).
  - A FETCH_WAIT-deep shift register shifts fetch_time on each cend.
  - condition = mode_a_text ? fetch_time : last stage.
  - fetch_start = registered (pre_cend && condition).
- Simultaneous events:
  - init at hcount==HPERIOD-1 gives a single wrap to 0.
  - init mid-line also clears the fetch pipeline on the same cend; levels are left untouched and resolve at their next compare point.
- mode_a_text toggling mid-line is applied combinationally. A pending pipeline token may yield a second fetch_start; this is accepted and is software's responsibility.
- Elaboration checks (generate-time $error):
  - HSYNC_BEG<HSYNC_END<HPERIOD;
  - every HPIX_BEG_n >= FETCH_FOREGO+FETCH_WAIT;
  - HPIX_BEG_n < HPIX_END_n < HPERIOD;
  - HPERIOD <= 2**CW.

Decomposition:
- Shared package video_timing_pkg holds:
  - default timing constants (HPERIOD, HSYNC_*, HBLNK_END, SCANIN_BEG, HINT_BEG, FETCH_FOREGO);
  - the four mode window pairs;
  - the 2-bit mode encoding.
- The package is reused by the future vertical generator.
- One natural sub-module: video_fetch_delay, the FETCH_WAIT-stage cend-enabled shift register with synchronous clear and async reset.

Test Plan:
- Free run with cend every 4 clk (pre_cend 1 clk earlier), mode 0 → hcount wraps 447→0, line_end once per 448 cend, hsync high for exactly 33 cend, hpix high for exactly 256 cend starting the cend after hcount=140.
- Mode 0, text=0 → fetch_start pulse 1 clk wide 18 cend before hpix rise; fetch_end at hcount=378. Same with text=1 → fetch_start 4 cend earlier (hcount=118).
- mode_sel 0→1 at hcount=200 → current line keeps hpix window 140..396; next line uses 108..428 (320 px).
- init asserted at hcount=300 → hcount=0 on that cend, fetch pipeline cleared, no spurious fetch_start, next line_start at hcount=88.
- hsync_pol=1 → hsync idles high, low for 33 cend; reset value high.
- rst_n low for 3 clk mid-line (hpix=1) → all outputs 0 (hsync=pol) immediately, asynchronously; counting resumes from 0 after release.

Source files
------------

// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared timing constants for the video sync generators.
//   - default horizontal timing (line period, sync, blank, scan-in, INT, fetch)
//   - the four horizontal pixel-window modes and their 2-bit encoding
// Used by video_sync_h_gen and intended for reuse by the vertical generator.
// No ports (package).
// -----------------------------------------------------------------------------
package video_timing_pkg;

  // Default horizontal timing, all in cend (7 MHz pixel) cycles
  localparam int DEF_CW           = 9;
  localparam int DEF_HPERIOD      = 448;
  localparam int DEF_HSYNC_BEG    = 10;
  localparam int DEF_HSYNC_END    = 43;
  localparam int DEF_HBLNK_END    = 88;
  localparam int DEF_SCANIN_BEG   = 88;
  localparam int DEF_HINT_BEG     = 2;
  localparam int DEF_FETCH_FOREGO = 18;
  localparam int DEF_FETCH_WAIT   = 4;

  // Pixel windows: begin/end hcount per mode
  localparam int DEF_HPIX_BEG_0 = 140;  // Pentagon 256 px
  localparam int DEF_HPIX_END_0 = 396;
  localparam int DEF_HPIX_BEG_1 = 108;  // ATM 320 px
  localparam int DEF_HPIX_END_1 = 428;
  localparam int DEF_HPIX_BEG_2 = 124;  // 288 px
  localparam int DEF_HPIX_END_2 = 412;
  localparam int DEF_HPIX_BEG_3 = 100;  // 336 px
  localparam int DEF_HPIX_END_3 = 436;

  // Pixel-window mode encoding
  typedef enum logic [1:0] {
    MODE_PENT256 = 2'd0,
    MODE_ATM320  = 2'd1,
    MODE_W288    = 2'd2,
    MODE_W336    = 2'd3
  } hmode_e;

  // Window width in pixels for a begin/end pair (informational helper)
  function automatic int win_width(input int beg_pos, input int end_pos);
    return end_pos - beg_pos;
  endfunction

endpackage : video_timing_pkg

// File: rtl/video_fetch_delay.sv
// -----------------------------------------------------------------------------
// video_fetch_delay
// DEPTH-stage shift register advanced on each pixel-cycle enable. Used to
// delay the fetch trigger in non-text modes.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (all stages cleared)
//   en    : shift enable (cend)
//   clr   : synchronous clear, wins over en
//   din   : bit shifted into stage 0
//   dout  : last stage
// -----------------------------------------------------------------------------
module video_fetch_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_r;

  // Shift chain: clear has priority, otherwise shift on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= {DEPTH{1'b0}};
    end else if (clr) begin
      stage_r <= {DEPTH{1'b0}};
    end else if (en) begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end else begin
      stage_r <= stage_r;
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule : video_fetch_delay

// File: rtl/video_sync_h_gen.sv
// -----------------------------------------------------------------------------
// video_sync_h_gen
// Horizontal video timing generator. Counts pixel cycles (cend) over a line of
// HPERIOD cycles and produces blank/sync/pixel levels, single-clock event
// strobes aligned with cend, and fetch start/end strobes for the fetcher.
// Ports:
//   clk          : system clock (28 MHz)
//   rst_n        : asynchronous active-low reset
//   init         : phase init, sampled when cend=1 (forces hcount to 0)
//   cend         : pixel-cycle strobe
//   pre_cend     : strobe one clk before cend
//   mode_sel     : requested pixel-window mode (taken at line wrap / init)
//   mode_a_text  : text mode, fetch without the FETCH_WAIT delay
//   hsync_pol    : 0 active-high hsync, 1 active-low
//   hcount       : current horizontal count
//   hblank,hsync,hpix : levels
//   line_start, hsync_start, scanin_start, hint_start,
//   fetch_start, fetch_end, line_end : one-clk strobes coinciding with cend
// -----------------------------------------------------------------------------
module video_sync_h_gen
  import video_timing_pkg::*;
#(
  parameter int CW           = DEF_CW,
  parameter int HPERIOD      = DEF_HPERIOD,
  parameter int HSYNC_BEG    = DEF_HSYNC_BEG,
  parameter int HSYNC_END    = DEF_HSYNC_END,
  parameter int HBLNK_END    = DEF_HBLNK_END,
  parameter int SCANIN_BEG   = DEF_SCANIN_BEG,
  parameter int HINT_BEG     = DEF_HINT_BEG,
  parameter int FETCH_FOREGO = DEF_FETCH_FOREGO,
  parameter int FETCH_WAIT   = DEF_FETCH_WAIT,
  parameter int HPIX_BEG_0   = DEF_HPIX_BEG_0,
  parameter int HPIX_END_0   = DEF_HPIX_END_0,
  parameter int HPIX_BEG_1   = DEF_HPIX_BEG_1,
  parameter int HPIX_END_1   = DEF_HPIX_END_1,
  parameter int HPIX_BEG_2   = DEF_HPIX_BEG_2,
  parameter int HPIX_END_2   = DEF_HPIX_END_2,
  parameter int HPIX_BEG_3   = DEF_HPIX_BEG_3,
  parameter int HPIX_END_3   = DEF_HPIX_END_3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          cend,
  input  logic          pre_cend,
  input  logic [1:0]    mode_sel,
  input  logic          mode_a_text,
  input  logic          hsync_pol,
  output logic [CW-1:0] hcount,
  output logic          hblank,
  output logic          hsync,
  output logic          line_start,
  output logic          hsync_start,
  output logic          scanin_start,
  output logic          hint_start,
  output logic          hpix,
  output logic          fetch_start,
  output logic          fetch_end,
  output logic          line_end
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  localparam int MIN_PIX_BEG = FETCH_FOREGO + FETCH_WAIT;

  if (!((HSYNC_BEG < HSYNC_END) && (HSYNC_END < HPERIOD))) begin : g_err_hsync
    $error("video_sync_h_gen: require HSYNC_BEG < HSYNC_END < HPERIOD");
  end
  if (FETCH_WAIT < 1) begin : g_err_wait
    $error("video_sync_h_gen: FETCH_WAIT must be at least 1");
  end
  if ((HPIX_BEG_0 < MIN_PIX_BEG) || (HPIX_BEG_1 < MIN_PIX_BEG) ||
      (HPIX_BEG_2 < MIN_PIX_BEG) || (HPIX_BEG_3 < MIN_PIX_BEG)) begin : g_err_forego
    $error("video_sync_h_gen: every HPIX_BEG_n must be >= FETCH_FOREGO+FETCH_WAIT");
  end
  if (!((HPIX_BEG_0 < HPIX_END_0) && (HPIX_END_0 < HPERIOD) &&
        (HPIX_BEG_1 < HPIX_END_1) && (HPIX_END_1 < HPERIOD) &&
        (HPIX_BEG_2 < HPIX_END_2) && (HPIX_END_2 < HPERIOD) &&
        (HPIX_BEG_3 < HPIX_END_3) && (HPIX_END_3 < HPERIOD))) begin : g_err_window
    $error("video_sync_h_gen: require HPIX_BEG_n < HPIX_END_n < HPERIOD");
  end
  if (longint'(HPERIOD) > (longint'(1) << CW)) begin : g_err_width
    $error("video_sync_h_gen: HPERIOD does not fit in CW bits");
  end

  // ---------------------------------------------------------------------------
  // Compare points at counter width
  // ---------------------------------------------------------------------------
  localparam logic [CW-1:0] LAST_C       = CW'(HPERIOD - 1);
  localparam logic [CW-1:0] ZERO_C       = CW'(0);
  localparam logic [CW-1:0] HSYNC_BEG_C  = CW'(HSYNC_BEG);
  localparam logic [CW-1:0] HSYNC_END_C  = CW'(HSYNC_END);
  localparam logic [CW-1:0] HBLNK_END_C  = CW'(HBLNK_END);
  localparam logic [CW-1:0] SCANIN_BEG_C = CW'(SCANIN_BEG);
  localparam logic [CW-1:0] HINT_BEG_C   = CW'(HINT_BEG);

  // Fetch trigger sits FETCH_FOREGO+FETCH_WAIT before the window opens; the
  // delay line re-adds FETCH_WAIT in graphic modes, text mode skips it.
  localparam logic [CW-1:0] FT_BEG_0_C = CW'(HPIX_BEG_0 - FETCH_FOREGO - FETCH_WAIT);
  localparam logic [CW-1:0] FT_BEG_1_C = CW'(HPIX_BEG_1 - FETCH_FOREGO - FETCH_WAIT);
  localparam logic [CW-1:0] FT_BEG_2_C = CW'(HPIX_BEG_2 - FETCH_FOREGO - FETCH_WAIT);
  localparam logic [CW-1:0] FT_BEG_3_C = CW'(HPIX_BEG_3 - FETCH_FOREGO - FETCH_WAIT);
  localparam logic [CW-1:0] FT_END_0_C = CW'(HPIX_END_0 - FETCH_FOREGO);
  localparam logic [CW-1:0] FT_END_1_C = CW'(HPIX_END_1 - FETCH_FOREGO);
  localparam logic [CW-1:0] FT_END_2_C = CW'(HPIX_END_2 - FETCH_FOREGO);
  localparam logic [CW-1:0] FT_END_3_C = CW'(HPIX_END_3 - FETCH_FOREGO);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] hcount_r;
  hmode_e        mode_r;
  logic          hblank_r;
  logic          sync_r;
  logic          hpix_r;
  logic          line_start_r;
  logic          hsync_start_r;
  logic          scanin_start_r;
  logic          hint_start_r;
  logic          fetch_start_r;
  logic          fetch_end_r;
  logic          line_end_r;

  logic          wrap_s;
  logic [CW-1:0] pix_beg_s;
  logic [CW-1:0] pix_end_s;
  logic [CW-1:0] ft_beg_s;
  logic [CW-1:0] ft_end_s;
  logic          fetch_time_s;
  logic          fetch_dly_s;
  logic          fetch_cond_s;
  logic          pipe_clr_s;

  // init forces a wrap, and coincides harmlessly with the natural one
  assign wrap_s     = init || (hcount_r == LAST_C);
  assign pipe_clr_s = cend && init;

  // Window compare points for the shadowed mode
  always_comb begin
    pix_beg_s = CW'(HPIX_BEG_0);
    pix_end_s = CW'(HPIX_END_0);
    ft_beg_s  = FT_BEG_0_C;
    ft_end_s  = FT_END_0_C;
    case (mode_r)
      MODE_PENT256: begin
        pix_beg_s = CW'(HPIX_BEG_0);
        pix_end_s = CW'(HPIX_END_0);
        ft_beg_s  = FT_BEG_0_C;
        ft_end_s  = FT_END_0_C;
      end
      MODE_ATM320: begin
        pix_beg_s = CW'(HPIX_BEG_1);
        pix_end_s = CW'(HPIX_END_1);
        ft_beg_s  = FT_BEG_1_C;
        ft_end_s  = FT_END_1_C;
      end
      MODE_W288: begin
        pix_beg_s = CW'(HPIX_BEG_2);
        pix_end_s = CW'(HPIX_END_2);
        ft_beg_s  = FT_BEG_2_C;
        ft_end_s  = FT_END_2_C;
      end
      MODE_W336: begin
        pix_beg_s = CW'(HPIX_BEG_3);
        pix_end_s = CW'(HPIX_END_3);
        ft_beg_s  = FT_BEG_3_C;
        ft_end_s  = FT_END_3_C;
      end
      default: begin
        pix_beg_s = CW'(HPIX_BEG_0);
        pix_end_s = CW'(HPIX_END_0);
        ft_beg_s  = FT_BEG_0_C;
        ft_end_s  = FT_END_0_C;
      end
    endcase
  end

  assign fetch_time_s = (hcount_r == ft_beg_s);

  // Horizontal counter and mode shadow, both advanced only on cend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_r <= ZERO_C;
      mode_r   <= MODE_PENT256;
    end else if (cend) begin
      if (wrap_s) begin
        hcount_r <= ZERO_C;
        mode_r   <= hmode_e'(mode_sel);
      end else begin
        hcount_r <= hcount_r + CW'(1);
        mode_r   <= mode_r;
      end
    end else begin
      hcount_r <= hcount_r;
      mode_r   <= mode_r;
    end
  end

  // Levels: set/clear from the count being left on this cend. An init does
  // not force them; they settle at their next compare point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hblank_r <= 1'b0;
      sync_r   <= 1'b0;
      hpix_r   <= 1'b0;
    end else if (cend) begin
      if (hcount_r == ZERO_C) begin
        hblank_r <= 1'b1;
      end else if (hcount_r == HBLNK_END_C) begin
        hblank_r <= 1'b0;
      end else begin
        hblank_r <= hblank_r;
      end

      if (hcount_r == HSYNC_BEG_C) begin
        sync_r <= 1'b1;
      end else if (hcount_r == HSYNC_END_C) begin
        sync_r <= 1'b0;
      end else begin
        sync_r <= sync_r;
      end

      if (hcount_r == pix_beg_s) begin
        hpix_r <= 1'b1;
      end else if (hcount_r == pix_end_s) begin
        hpix_r <= 1'b0;
      end else begin
        hpix_r <= hpix_r;
      end
    end else begin
      hblank_r <= hblank_r;
      sync_r   <= sync_r;
      hpix_r   <= hpix_r;
    end
  end

  // Delay line for the graphic-mode fetch trigger; init flushes pending tokens
  video_fetch_delay #(
    .DEPTH (FETCH_WAIT)
  ) u_fetch_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cend),
    .clr   (pipe_clr_s),
    .din   (fetch_time_s),
    .dout  (fetch_dly_s)
  );

  // Text mode bypasses the delay line; selection follows mode_a_text live
  always_comb begin
    fetch_cond_s = fetch_dly_s;
    if (mode_a_text) begin
      fetch_cond_s = fetch_time_s;
    end else begin
      fetch_cond_s = fetch_dly_s;
    end
  end

  // Strobes: loaded on the pre_cend clock so they are high during the cend clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_r   <= 1'b0;
      hsync_start_r  <= 1'b0;
      scanin_start_r <= 1'b0;
      hint_start_r   <= 1'b0;
      fetch_start_r  <= 1'b0;
      fetch_end_r    <= 1'b0;
      line_end_r     <= 1'b0;
    end else begin
      line_start_r   <= pre_cend && (hcount_r == HBLNK_END_C);
      hsync_start_r  <= pre_cend && (hcount_r == HSYNC_BEG_C);
      scanin_start_r <= pre_cend && (hcount_r == SCANIN_BEG_C);
      hint_start_r   <= pre_cend && (hcount_r == HINT_BEG_C);
      fetch_start_r  <= pre_cend && fetch_cond_s;
      fetch_end_r    <= pre_cend && (hcount_r == ft_end_s);
      line_end_r     <= pre_cend && (hcount_r == LAST_C);
    end
  end

  assign hcount       = hcount_r;
  assign hblank       = hblank_r;
  // Polarity is a static configuration; sync_r resets to 0 so hsync idles at hsync_pol
  assign hsync        = sync_r ^ hsync_pol;
  assign hpix         = hpix_r;
  assign line_start   = line_start_r;
  assign hsync_start  = hsync_start_r;
  assign scanin_start = scanin_start_r;
  assign hint_start   = hint_start_r;
  assign fetch_start  = fetch_start_r;
  assign fetch_end    = fetch_end_r;
  assign line_end     = line_end_r;

endmodule : video_sync_h_gen

// File: tb/tb_video_sync_h_gen.sv
// -----------------------------------------------------------------------------
// tb_video_sync_h_gen
// Directed bench for video_sync_h_gen with default parameters. cend every
// 4 clk with pre_cend one clk earlier. Per pixel cycle the outputs are
// snapshotted in the clk where cend is high (strobes valid there).
// -----------------------------------------------------------------------------
module tb_video_sync_h_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init;
  logic       cend;
  logic       pre_cend;
  logic [1:0] mode_sel;
  logic       mode_a_text;
  logic       hsync_pol;
  logic [8:0] hcount;
  logic       hblank, hsync, line_start, hsync_start, scanin_start, hint_start;
  logic       hpix, fetch_start, fetch_end, line_end;

  video_sync_h_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .cend         (cend),
    .pre_cend     (pre_cend),
    .mode_sel     (mode_sel),
    .mode_a_text  (mode_a_text),
    .hsync_pol    (hsync_pol),
    .hcount       (hcount),
    .hblank       (hblank),
    .hsync        (hsync),
    .line_start   (line_start),
    .hsync_start  (hsync_start),
    .scanin_start (scanin_start),
    .hint_start   (hint_start),
    .hpix         (hpix),
    .fetch_start  (fetch_start),
    .fetch_end    (fetch_end),
    .line_end     (line_end)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Per-line statistics, filled by run_line
  int   bad_h, stray, cnt_hs, cnt_px, cnt_hb, first_px;
  int   n_fs, pos_fs, n_fe, pos_fe, n_le, pos_le;
  int   pos_ls, pos_hss, pos_sis, pos_his;
  logic hs0;

  function automatic logic any_strobe();
    return line_start | hsync_start | scanin_start | hint_start |
           fetch_start | fetch_end | line_end;
  endfunction

  // One pixel cycle: 4 clks; returns at the negedge inside the cend clk
  task automatic step(input logic do_init);
    @(negedge clk);
    pre_cend = 1'b0; cend = 1'b0; init = 1'b0;
    if (any_strobe()) stray++;
    @(negedge clk);
    if (any_strobe()) stray++;
    @(negedge clk);
    pre_cend = 1'b1;
    @(negedge clk);
    pre_cend = 1'b0; cend = 1'b1; init = do_init;
  endtask

  // Runs n pixel cycles assuming the line starts at hcount 0
  task automatic run_line(input int n, input int init_at, input int chg_at,
                          input logic [1:0] chg_mode);
    bad_h = 0; stray = 0; cnt_hs = 0; cnt_px = 0; cnt_hb = 0; first_px = -1;
    n_fs = 0; pos_fs = -1; n_fe = 0; pos_fe = -1; n_le = 0; pos_le = -1;
    pos_ls = -1; pos_hss = -1; pos_sis = -1; pos_his = -1; hs0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == chg_at) mode_sel = chg_mode;
      step(i == init_at);
      if (hcount !== i[8:0]) bad_h++;
      if (i == 0) hs0 = hsync;
      if (hsync === 1'b1) cnt_hs++;
      if (hblank === 1'b1) cnt_hb++;
      if (hpix === 1'b1) begin cnt_px++; if (first_px < 0) first_px = i; end
      if (fetch_start === 1'b1) begin n_fs++; if (pos_fs < 0) pos_fs = i; end
      if (fetch_end === 1'b1) begin n_fe++; if (pos_fe < 0) pos_fe = i; end
      if (line_end === 1'b1) begin n_le++; if (pos_le < 0) pos_le = i; end
      if (line_start === 1'b1 && pos_ls < 0) pos_ls = i;
      if (hsync_start === 1'b1 && pos_hss < 0) pos_hss = i;
      if (scanin_start === 1'b1 && pos_sis < 0) pos_sis = i;
      if (hint_start === 1'b1 && pos_his < 0) pos_his = i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init = 1'b0; cend = 1'b0; pre_cend = 1'b0;
    mode_sel = 2'd0; mode_a_text = 1'b0; hsync_pol = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (hcount !== 9'd0 || hblank !== 1'b0 || hpix !== 1'b0 || hsync !== 1'b0) begin
      errs++;
      $display("FAIL reset_levels: got hcount=%0d hblank=%b hpix=%b hsync=%b, want 0 0 0 0",
               hcount, hblank, hpix, hsync);
    end
    checks++;
    if (any_strobe() !== 1'b0) begin
      errs++; $display("FAIL reset_strobes: got %b, want 0", any_strobe());
    end
    hsync_pol = 1'b1;
    #1;
    checks++;
    if (hsync !== 1'b1) begin
      errs++; $display("FAIL reset_hsync_pol1: got %b, want 1", hsync);
    end
    hsync_pol = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (bad_h !== 0) begin errs++; $display("FAIL hcount_line1: %0d bad steps, want 0", bad_h); end
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (bad_h !== 0) begin errs++; $display("FAIL hcount_wrap: %0d bad steps, want 0", bad_h); end
    checks++;
    if (n_le !== 1 || pos_le !== 447) begin
      errs++; $display("FAIL line_end: got n=%0d pos=%0d, want n=1 pos=447", n_le, pos_le);
    end
    checks++;
    if (cnt_hs !== 33) begin errs++; $display("FAIL hsync_width: got %0d, want 33", cnt_hs); end
    checks++;
    if (cnt_px !== 256 || first_px !== 141) begin
      errs++; $display("FAIL hpix_mode0: got cnt=%0d first=%0d, want 256 141", cnt_px, first_px);
    end
    checks++;
    if (cnt_hb !== 88) begin errs++; $display("FAIL hblank_width: got %0d, want 88", cnt_hb); end
    checks++;
    if (pos_hss !== 10 || pos_ls !== 88 || pos_sis !== 88 || pos_his !== 2) begin
      errs++;
      $display("FAIL strobe_pos: got hss=%0d ls=%0d sis=%0d his=%0d, want 10 88 88 2",
               pos_hss, pos_ls, pos_sis, pos_his);
    end
    checks++;
    if (stray !== 0) begin errs++; $display("FAIL strobe_width: got %0d stray, want 0", stray); end
  endtask

  task automatic test_fetch();
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (n_fs !== 1 || pos_fs !== 122) begin
      errs++; $display("FAIL fetch_start_gfx: got n=%0d pos=%0d, want 1 122", n_fs, pos_fs);
    end
    checks++;
    if (n_fe !== 1 || pos_fe !== 378) begin
      errs++; $display("FAIL fetch_end_mode0: got n=%0d pos=%0d, want 1 378", n_fe, pos_fe);
    end
    mode_a_text = 1'b1;
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (n_fs !== 1 || pos_fs !== 118) begin
      errs++; $display("FAIL fetch_start_text: got n=%0d pos=%0d, want 1 118", n_fs, pos_fs);
    end
    mode_a_text = 1'b0;
  endtask

  task automatic test_mode_switch();
    run_line(448, -1, 200, 2'd1);
    checks++;
    if (cnt_px !== 256 || first_px !== 141) begin
      errs++; $display("FAIL mode_shadow: got cnt=%0d first=%0d, want 256 141", cnt_px, first_px);
    end
    run_line(448, -1, 200, 2'd0);
    checks++;
    if (cnt_px !== 320 || first_px !== 109) begin
      errs++; $display("FAIL hpix_mode1: got cnt=%0d first=%0d, want 320 109", cnt_px, first_px);
    end
    checks++;
    if (pos_fs !== 90 || pos_fe !== 410) begin
      errs++; $display("FAIL fetch_mode1: got fs=%0d fe=%0d, want 90 410", pos_fs, pos_fe);
    end
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (first_px !== 141) begin
      errs++; $display("FAIL mode_back0: got first=%0d, want 141", first_px);
    end
  endtask

  task automatic test_init();
    run_line(301, 300, -1, 2'd0);
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (bad_h !== 0) begin errs++; $display("FAIL init_mid: %0d bad steps, want 0", bad_h); end
    checks++;
    if (pos_ls !== 88) begin errs++; $display("FAIL init_line_start: got %0d, want 88", pos_ls); end
    // init while a fetch token is in the delay line
    run_line(121, 120, -1, 2'd0);
    checks++;
    if (n_fs !== 0) begin errs++; $display("FAIL init_fetch_pre: got n=%0d, want 0", n_fs); end
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (n_fs !== 1 || pos_fs !== 122) begin
      errs++; $display("FAIL init_pipe_clear: got n=%0d pos=%0d, want 1 122", n_fs, pos_fs);
    end
    // init on the last count gives one wrap only
    run_line(448, 447, -1, 2'd0);
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (bad_h !== 0) begin errs++; $display("FAIL init_at_wrap: %0d bad steps, want 0", bad_h); end
  endtask

  task automatic test_hsync_pol();
    hsync_pol = 1'b1;
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (hs0 !== 1'b1 || cnt_hs !== 415) begin
      errs++; $display("FAIL hsync_pol1: got idle=%b high=%0d, want 1 415", hs0, cnt_hs);
    end
    hsync_pol = 1'b0;
  endtask

  task automatic test_async_reset();
    run_line(201, -1, -1, 2'd0);
    checks++;
    if (hpix !== 1'b1) begin errs++; $display("FAIL pre_reset_hpix: got %b, want 1", hpix); end
    @(negedge clk);
    pre_cend = 1'b0; cend = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hcount !== 9'd0 || hpix !== 1'b0 || hblank !== 1'b0 || hsync !== 1'b0 ||
        any_strobe() !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: got hcount=%0d hpix=%b hblank=%b hsync=%b, want 0 0 0 0",
               hcount, hpix, hblank, hsync);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_line(448, -1, -1, 2'd0);
    checks++;
    if (bad_h !== 0 || first_px !== 141) begin
      errs++; $display("FAIL post_reset: got bad=%0d first=%0d, want 0 141", bad_h, first_px);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_fetch();
    test_mode_switch();
    test_init();
    test_hsync_pol();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_video_sync_h_gen
